// File: rtl/ad7124_sequencer_if.sv
// SPI-master handshake between the AD7124 command sequencer and the 32-bit SPI master.
//   spi_data_o  : frame toward the master's parallel load input
//   spi_data_ie : one-cycle load strobe toward the master
//   spi_data_i  : last frame received by the master
//   spi_wr_en   : one-cycle frame-complete pulse from the master
// modport master: sequencer side; modport slave: SPI master side.
interface ad7124_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] spi_data_o;
  logic             spi_data_ie;
  logic [WIDTH-1:0] spi_data_i;
  logic             spi_wr_en;

  modport master (
    output spi_data_o,
    output spi_data_ie,
    input  spi_data_i,
    input  spi_wr_en
  );

  modport slave (
    input  spi_data_o,
    input  spi_data_ie,
    output spi_data_i,
    output spi_wr_en
  );
endinterface

// File: rtl/ad7124_sequencer.sv
// AD7124 command sequencer. Sends the 64-ones reset, waits, writes the configuration frames,
// then loops: poll status until RDY_N clears, read the 24-bit data register, publish a sample.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   enable       : run level; a drop takes effect at the next frame boundary (or in RWAIT/CHK)
//   cfg_words    : N_CFG config frames, frame k at [k*WIDTH +: WIDTH], k=0 sent first
//   spi          : handshake with the SPI master (master modport)
//   sample_data  : last conversion result; sample_chan: its channel (status[3:0])
//   sample_valid : one-cycle pulse per new sample
//   busy         : high whenever the sequencer is not idle
//   timeout_err  : sticky status-poll timeout, cleared by reset or an enable rising edge
module ad7124_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_CFG    = 4,
  parameter logic [15:0] RST_WAIT = 16'd4000,
  parameter logic [15:0] POLL_MAX = 16'd50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [N_CFG*WIDTH-1:0] cfg_words,
  ad7124_sequencer_if.master     spi,
  output logic [23:0]            sample_data,
  output logic [3:0]             sample_chan,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam logic [WIDTH-1:0] FRAME_RST     = '1;
  localparam logic [WIDTH-1:0] FRAME_RD_STAT = {8'h40, {(WIDTH-8){1'b0}}};
  localparam logic [WIDTH-1:0] FRAME_RD_DATA = {8'h42, {(WIDTH-8){1'b0}}};
  localparam logic [3:0]       CFG_LAST      = 4'(N_CFG - 1);
  localparam logic [15:0]      POLL_LAST     = POLL_MAX - 16'd1;

  typedef enum logic [2:0] {
    StIdle, StRst0, StRst1, StRwait, StCfg, StPoll, StChk, StData
  } state_e;

  state_e           state_q;
  logic [3:0]       cfg_idx_q;
  logic [15:0]      wait_cnt_q;
  logic [15:0]      poll_cnt_q;
  logic [7:0]       status_q;
  logic             enable_q;

  logic [3:0]       cfg_idx_inc;
  logic [WIDTH-1:0] cfg_word_nxt;
  logic             wait_done;
  logic             unused_bits;

  assign cfg_idx_inc = cfg_idx_q + 4'd1;
  // RST_WAIT of 0 still spends the single RWAIT cycle.
  assign wait_done   = (wait_cnt_q + 16'd1) >= RST_WAIT;
  assign unused_bits = ^{spi.spi_data_i[WIDTH-1:24], status_q[6:4]};

  // Mux for the config frame following the current one.
  always_comb begin
    cfg_word_nxt = '0;
    for (int unsigned k = 0; k < N_CFG; k++) begin
      if (k == 32'(cfg_idx_inc)) cfg_word_nxt = cfg_words[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= StIdle;
      cfg_idx_q       <= '0;
      wait_cnt_q      <= '0;
      poll_cnt_q      <= '0;
      status_q        <= '0;
      enable_q        <= 1'b0;
      spi.spi_data_o  <= '0;
      spi.spi_data_ie <= 1'b0;
      sample_data     <= '0;
      sample_chan     <= '0;
      sample_valid    <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      spi.spi_data_ie <= 1'b0;
      sample_valid    <= 1'b0;
      enable_q        <= enable;
      if (enable && !enable_q) timeout_err <= 1'b0;

      // Every transition into a TX state loads the frame and strobes once; the TX state then
      // waits for spi_wr_en, so the strobe cannot repeat while a frame is pending.
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q         <= StRst0;
            busy            <= 1'b1;
            spi.spi_data_o  <= FRAME_RST;
            spi.spi_data_ie <= 1'b1;
          end
        end
        StRst0: begin
          if (spi.spi_wr_en) begin
            if (!enable) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q         <= StRst1;
              spi.spi_data_o  <= FRAME_RST;
              spi.spi_data_ie <= 1'b1;
            end
          end
        end
        StRst1: begin
          if (spi.spi_wr_en) begin
            if (!enable) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q    <= StRwait;
              wait_cnt_q <= '0;
            end
          end
        end
        StRwait: begin
          if (!enable) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (wait_done) begin
            state_q         <= StCfg;
            cfg_idx_q       <= '0;
            spi.spi_data_o  <= cfg_words[WIDTH-1:0];
            spi.spi_data_ie <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StCfg: begin
          if (spi.spi_wr_en) begin
            if (!enable) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else if (cfg_idx_q == CFG_LAST) begin
              state_q         <= StPoll;
              spi.spi_data_o  <= FRAME_RD_STAT;
              spi.spi_data_ie <= 1'b1;
            end else begin
              cfg_idx_q       <= cfg_idx_inc;
              spi.spi_data_o  <= cfg_word_nxt;
              spi.spi_data_ie <= 1'b1;
            end
          end
        end
        StPoll: begin
          if (spi.spi_wr_en) begin
            status_q <= spi.spi_data_i[23:16];
            if (!enable) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StChk;
            end
          end
        end
        StChk: begin
          if (!enable) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (!status_q[7]) begin
            // RDY_N low: conversion ready
            poll_cnt_q      <= '0;
            state_q         <= StData;
            spi.spi_data_o  <= FRAME_RD_DATA;
            spi.spi_data_ie <= 1'b1;
          end else if (poll_cnt_q == POLL_LAST) begin
            timeout_err     <= 1'b1;
            poll_cnt_q      <= '0;
            state_q         <= StRst0;
            spi.spi_data_o  <= FRAME_RST;
            spi.spi_data_ie <= 1'b1;
          end else begin
            if (poll_cnt_q != 16'hFFFF) poll_cnt_q <= poll_cnt_q + 16'd1;
            state_q         <= StPoll;
            spi.spi_data_o  <= FRAME_RD_STAT;
            spi.spi_data_ie <= 1'b1;
          end
        end
        StData: begin
          if (spi.spi_wr_en) begin
            sample_data  <= spi.spi_data_i[23:0];
            sample_chan  <= status_q[3:0];
            sample_valid <= 1'b1;
            if (!enable) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q         <= StPoll;
              spi.spi_data_o  <= FRAME_RD_STAT;
              spi.spi_data_ie <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad7124_sequencer.sv
module tb_ad7124_sequencer;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned N_CFG    = 2;
  localparam logic [15:0] RST_WAIT = 16'd20;
  localparam logic [15:0] POLL_MAX = 16'd3;
  localparam int          LAT      = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [N_CFG*WIDTH-1:0] cfg_words = {32'h0900_8001, 32'h0100_0C00};
  logic [23:0] sample_data;
  logic [3:0]  sample_chan;
  logic        sample_valid, busy, timeout_err;
  logic        model_wr = 1'b0;
  logic        inject_wr = 1'b0;
  logic [31:0] model_rd = '0;

  ad7124_sequencer_if #(.WIDTH(WIDTH)) sif ();
  assign sif.spi_wr_en  = model_wr | inject_wr;
  assign sif.spi_data_i = model_rd;

  ad7124_sequencer #(
    .WIDTH(WIDTH), .N_CFG(N_CFG), .RST_WAIT(RST_WAIT), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_words(cfg_words), .spi(sif),
    .sample_data(sample_data), .sample_chan(sample_chan), .sample_valid(sample_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int violations = 0;
  logic [31:0] log_q[$];
  int          log_cyc[$];
  logic [7:0]  status_q[$];
  logic [23:0] data_q[$];

  // Bus model: answers each strobe with spi_wr_en LAT cycles later.
  initial begin
    int cd;
    logic [31:0] reply;
    logic [7:0] st;
    logic [23:0] d;
    cd = 0;
    reply = '0;
    forever begin
      @(negedge clk);
      model_wr = 1'b0;
      if (!rst) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            model_rd = reply;
            model_wr = 1'b1;
          end
        end
        if (sif.spi_data_ie) begin
          log_q.push_back(sif.spi_data_o);
          log_cyc.push_back(cyc);
          cd = LAT;
          if (sif.spi_data_o == 32'h4000_0000) begin
            if (status_q.size() > 0) st = status_q.pop_front();
            else st = 8'h80;
            reply = {8'h00, st, 16'h0000};
          end else if (sif.spi_data_o == 32'h4200_0000) begin
            if (data_q.size() > 0) d = data_q.pop_front();
            else d = 24'h0;
            reply = {8'hA5, d};
          end else begin
            reply = '0;
          end
        end
      end
    end
  end

  // Protocol monitor: no second strobe while a frame is pending.
  logic mon_pending = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      mon_pending = 1'b0;
    end else begin
      if (sif.spi_wr_en) mon_pending = 1'b0;
      if (sif.spi_data_ie) begin
        if (mon_pending) violations++;
        mon_pending = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    checks++; if (sif.spi_data_o !== 32'h0) begin errors++; $display("FAIL reset_data_o got %h want 0", sif.spi_data_o); end
    checks++; if (sif.spi_data_ie !== 1'b0) begin errors++; $display("FAIL reset_ie got %b want 0", sif.spi_data_ie); end
    checks++; if (sample_data !== 24'h0) begin errors++; $display("FAIL reset_sample got %h want 0", sample_data); end
    checks++; if (sample_chan !== 4'h0) begin errors++; $display("FAIL reset_chan got %h want 0", sample_chan); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
    rst = 1'b1;
    step();
    checks++; if (sif.spi_data_ie !== 1'b0) begin errors++; $display("FAIL idle_no_strobe got %b want 0", sif.spi_data_ie); end
  endtask

  task automatic test_bringup();
    logic [31:0] exp_frames [5];
    exp_frames[0] = 32'hFFFF_FFFF; exp_frames[1] = 32'hFFFF_FFFF; exp_frames[2] = 32'h0100_0C00;
    exp_frames[3] = 32'h0900_8001; exp_frames[4] = 32'h4000_0000;
    status_q.push_back(8'h85);
    status_q.push_back(8'h85);
    status_q.push_back(8'h02);
    data_q.push_back(24'h123456);
    enable = 1'b1;
    step();
    checks++; if (sif.spi_data_ie !== 1'b1) begin errors++; $display("FAIL start_ie got %b want 1", sif.spi_data_ie); end
    checks++; if (sif.spi_data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL start_frame got %h want ffffffff", sif.spi_data_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
    for (int i = 0; i < 2000; i++) begin
      if (log_q.size() >= 6) break;
      step();
    end
    checks++;
    if (log_q.size() < 6) begin
      errors++; $display("FAIL bringup_wait got %0d frames want 6", log_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (log_q[k] !== exp_frames[k]) begin
          errors++; $display("FAIL bringup_frame%0d got %h want %h", k, log_q[k], exp_frames[k]);
        end
      end
      checks++; if (log_cyc[1] - log_cyc[0] !== LAT + 1) begin errors++; $display("FAIL rst_gap got %0d want %0d", log_cyc[1] - log_cyc[0], LAT + 1); end
      checks++; if (log_cyc[2] - log_cyc[1] !== LAT + 1 + int'(RST_WAIT)) begin errors++; $display("FAIL rwait_gap got %0d want %0d", log_cyc[2] - log_cyc[1], LAT + 1 + int'(RST_WAIT)); end
      checks++; if (log_cyc[5] - log_cyc[4] !== LAT + 2) begin errors++; $display("FAIL poll_gap got %0d want %0d", log_cyc[5] - log_cyc[4], LAT + 2); end
    end
  endtask

  task automatic test_poll_sample();
    for (int i = 0; i < 1000; i++) begin
      if (sample_valid === 1'b1) break;
      step();
    end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL sample_wait got %b want 1", sample_valid); end
    checks++; if (sample_data !== 24'h123456) begin errors++; $display("FAIL sample_data got %h want 123456", sample_data); end
    checks++; if (sample_chan !== 4'h2) begin errors++; $display("FAIL sample_chan got %h want 2", sample_chan); end
    checks++; if (sif.spi_data_ie !== 1'b1 || sif.spi_data_o !== 32'h4000_0000) begin errors++; $display("FAIL post_data_poll got %b/%h want 1/40000000", sif.spi_data_ie, sif.spi_data_o); end
    checks++;
    if (log_q.size() < 9 || log_q[6] !== 32'h4000_0000 || log_q[7] !== 32'h4200_0000) begin
      errors++; $display("FAIL poll_sequence got %0d frames want 3 polls then one data read", log_q.size());
    end
    step();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b want 0", sample_valid); end
    checks++; if (sample_data !== 24'h123456) begin errors++; $display("FAIL sample_hold got %h want 123456", sample_data); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 1000; i++) begin
      if (timeout_err === 1'b1) break;
      step();
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", timeout_err); end
    checks++; if (sif.spi_data_ie !== 1'b1 || sif.spi_data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_rst got %b/%h want 1/ffffffff", sif.spi_data_ie, sif.spi_data_o); end
    checks++;
    if (log_q.size() !== 12 || log_q[10] !== 32'h4000_0000 || log_q[8] !== 32'h4000_0000) begin
      errors++; $display("FAIL timeout_polls got %0d frames want 12 (3 polls after sample)", log_q.size());
    end
    enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) break;
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_stop got busy %b want 0", busy); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", timeout_err); end
    step();
    enable = 1'b1;
    step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout_err); end
    checks++; if (sif.spi_data_ie !== 1'b1 || sif.spi_data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL restart got %b/%h want 1/ffffffff", sif.spi_data_ie, sif.spi_data_o); end
  endtask

  task automatic test_stop();
    int n;
    status_q.push_back(8'h05);
    data_q.push_back(24'hABCDEF);
    for (int i = 0; i < 2000; i++) begin
      if (sif.spi_data_ie === 1'b1 && sif.spi_data_o === 32'h4200_0000) break;
      step();
    end
    checks++; if (sif.spi_data_o !== 32'h4200_0000) begin errors++; $display("FAIL stop_reach_data got %h want 42000000", sif.spi_data_o); end
    repeat (5) step();
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sample_valid === 1'b1) break;
      step();
    end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL stop_valid got %b want 1", sample_valid); end
    checks++; if (sample_data !== 24'hABCDEF) begin errors++; $display("FAIL stop_data got %h want abcdef", sample_data); end
    checks++; if (sample_chan !== 4'h5) begin errors++; $display("FAIL stop_chan got %h want 5", sample_chan); end
    checks++; if (busy !== 1'b0 || sif.spi_data_ie !== 1'b0) begin errors++; $display("FAIL stop_idle got busy %b ie %b want 0 0", busy, sif.spi_data_ie); end
    n = log_q.size();
    repeat (100) step();
    checks++; if (log_q.size() !== n) begin errors++; $display("FAIL stop_quiet got %0d frames want %0d", log_q.size(), n); end
  endtask

  task automatic test_reset_mid_cfg();
    enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (sif.spi_data_ie === 1'b1 && sif.spi_data_o === 32'h0900_8001) break;
      step();
    end
    checks++; if (sif.spi_data_o !== 32'h0900_8001) begin errors++; $display("FAIL cfg1_reach got %h want 09008001", sif.spi_data_o); end
    repeat (5) step();
    rst = 1'b0;
    step();
    checks++; if (sif.spi_data_o !== 32'h0) begin errors++; $display("FAIL mid_rst_data_o got %h want 0", sif.spi_data_o); end
    checks++; if (sample_data !== 24'h0) begin errors++; $display("FAIL mid_rst_sample got %h want 0", sample_data); end
    checks++; if (sample_chan !== 4'h0) begin errors++; $display("FAIL mid_rst_chan got %h want 0", sample_chan); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (sif.spi_data_ie !== 1'b0 || sample_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got ie %b valid %b to %b want 0 0 0", sif.spi_data_ie, sample_valid, timeout_err); end
    rst = 1'b1;
    step();
    checks++; if (sif.spi_data_ie !== 1'b1 || sif.spi_data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_rst_restart got %b/%h want 1/ffffffff", sif.spi_data_ie, sif.spi_data_o); end
  endtask

  task automatic test_protocol();
    int idx0;
    idx0 = log_q.size() - 1;
    for (int i = 0; i < 200; i++) begin
      if (log_q.size() >= idx0 + 2) break;
      step();
    end
    repeat (45) step();
    inject_wr = 1'b1;
    step();
    inject_wr = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (log_q.size() >= idx0 + 3) break;
      step();
    end
    checks++;
    if (log_q.size() !== idx0 + 3) begin
      errors++; $display("FAIL spurious_frames got %0d want %0d", log_q.size(), idx0 + 3);
    end else begin
      checks++; if (log_q[idx0 + 2] !== 32'h0100_0C00) begin errors++; $display("FAIL spurious_cfg got %h want 01000c00", log_q[idx0 + 2]); end
      checks++; if (log_cyc[idx0 + 2] - log_cyc[idx0 + 1] !== LAT + 1 + int'(RST_WAIT)) begin errors++; $display("FAIL spurious_gap got %0d want %0d", log_cyc[idx0 + 2] - log_cyc[idx0 + 1], LAT + 1 + int'(RST_WAIT)); end
    end
    enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) break;
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL final_idle got busy %b want 0", busy); end
    checks++; if (violations !== 0) begin errors++; $display("FAIL double_strobe got %0d want 0", violations); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_poll_sample();
    test_timeout();
    test_stop();
    test_reset_mid_cfg();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
